// File: rtl/log_mult_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | log_mult_pkg : shared constants and width helper for log_mult_pipe   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package log_mult_pkg;

  localparam logic MODE_EXACT    = 1'b0;
  localparam logic MODE_MITCHELL = 1'b1;

  // Width of a bit index into a WIDTH-bit word (at least 1 bit).
  function automatic int lod_idx_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage
`default_nettype wire

// File: rtl/log_mult_pipe_lod.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lod      : leading-one detector, returns MSB index and a zero flag   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module lod
  import log_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = lod_idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] value,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  // Later (higher) set bits overwrite earlier ones, leaving the MSB index.
  always_comb begin
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) idx = IDX_W'(i);
    end
  end

  assign zero = (value == '0);

endmodule
`default_nettype wire

// File: rtl/log_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | log_mult_pipe : 3-stage unsigned multiplier, exact or Mitchell mode  |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module log_mult_pipe
  import log_mult_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_mode,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int F   = WIDTH - 1;
  localparam int P_W = 2 * WIDTH;
  localparam int L_W = 3 * WIDTH - 1;
  localparam int IW  = lod_idx_w(WIDTH);
  localparam int K_W = IW + 1;
  localparam logic [K_W-1:0] c_k_one = K_W'(1);

  logic w_advance;
  assign w_advance = !(out_valid && !out_ready);
  assign in_ready  = w_advance;

  // Stage 1 combinational: leading-one positions and normalised fractions.
  logic [IW-1:0] w_ka, w_kb;
  logic          w_za, w_zb;
  logic [F-1:0]  w_xa, w_xb;

  lod #(.WIDTH(WIDTH)) u_lod_a (.value(in_a), .idx(w_ka), .zero(w_za));
  lod #(.WIDTH(WIDTH)) u_lod_b (.value(in_b), .idx(w_kb), .zero(w_zb));

  assign w_xa = F'(in_a << (IW'(F) - w_ka));
  assign w_xb = F'(in_b << (IW'(F) - w_kb));

  logic               r_s1_valid, r_s1_mode, r_s1_zero;
  logic [TAG_W-1:0]   r_s1_tag;
  logic [WIDTH-1:0]   r_s1_a, r_s1_b;
  logic [IW-1:0]      r_s1_ka, r_s1_kb;
  logic [F-1:0]       r_s1_xa, r_s1_xb;

  // Stage 2 combinational: exact product and log-domain sum.
  logic [P_W-1:0]   w_prod;
  logic [K_W-1:0]   w_k;
  logic [WIDTH-1:0] w_x;

  assign w_prod = P_W'(r_s1_a) * P_W'(r_s1_b);
  assign w_k    = K_W'(r_s1_ka) + K_W'(r_s1_kb);
  assign w_x    = WIDTH'(r_s1_xa) + WIDTH'(r_s1_xb);

  logic               r_s2_valid, r_s2_mode, r_s2_zero;
  logic [TAG_W-1:0]   r_s2_tag;
  logic [P_W-1:0]     r_s2_prod;
  logic [K_W-1:0]     r_s2_k;
  logic [WIDTH-1:0]   r_s2_x;

  // Stage 3 combinational: antilog; a fraction carry doubles the mantissa.
  logic [L_W-1:0] w_lin;
  logic [P_W-1:0] w_result;

  always_comb begin
    if (r_s2_x[F]) w_lin = L_W'(r_s2_x) << (r_s2_k + c_k_one);
    else           w_lin = L_W'({1'b1, r_s2_x[F-1:0]}) << r_s2_k;
    if (r_s2_mode == MODE_EXACT) w_result = r_s2_prod;
    else if (r_s2_zero)          w_result = '0;
    else                         w_result = P_W'(w_lin >> F);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_ka    <= '0;
      r_s1_kb    <= '0;
      r_s1_xa    <= '0;
      r_s1_xb    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_zero  <= 1'b0;
      r_s2_tag   <= '0;
      r_s2_prod  <= '0;
      r_s2_k     <= '0;
      r_s2_x     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_mode   <= 1'b0;
      out_tag    <= '0;
    end else if (w_advance) begin
      r_s1_valid <= in_valid;
      r_s1_mode  <= in_mode;
      r_s1_zero  <= w_za | w_zb;
      r_s1_tag   <= in_tag;
      r_s1_a     <= in_a;
      r_s1_b     <= in_b;
      r_s1_ka    <= w_ka;
      r_s1_kb    <= w_kb;
      r_s1_xa    <= w_xa;
      r_s1_xb    <= w_xb;
      r_s2_valid <= r_s1_valid;
      r_s2_mode  <= r_s1_mode;
      r_s2_zero  <= r_s1_zero;
      r_s2_tag   <= r_s1_tag;
      r_s2_prod  <= w_prod;
      r_s2_k     <= w_k;
      r_s2_x     <= w_x;
      out_valid  <= r_s2_valid;
      out_result <= w_result;
      out_mode   <= r_s2_mode;
      out_tag    <= r_s2_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_log_mult_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_log_mult_pipe : scoreboard bench for 8-bit and 16-bit instances   |
// | Revision         : 1.0                                               |
// +----------------------------------------------------------------------+
module tb_log_mult_pipe;
  import log_mult_pkg::*;

  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [7:0]    in_a, in_b;
  logic [TW-1:0] in_tag, out_tag;
  logic [15:0]   out_result;

  logic          d16_in_valid, d16_in_ready, d16_in_mode, d16_out_valid, d16_out_ready, d16_out_mode;
  logic [15:0]   d16_in_a, d16_in_b;
  logic [TW-1:0] d16_in_tag, d16_out_tag;
  logic [31:0]   d16_out_result;

  log_mult_pipe #(.WIDTH(8), .TAG_W(TW)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_mode(out_mode), .out_tag(out_tag)
  );

  log_mult_pipe #(.WIDTH(16), .TAG_W(TW)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
    .in_a(d16_in_a), .in_b(d16_in_b), .in_mode(d16_in_mode), .in_tag(d16_in_tag),
    .out_valid(d16_out_valid), .out_ready(d16_out_ready), .out_result(d16_out_result),
    .out_mode(d16_out_mode), .out_tag(d16_out_tag)
  );

  typedef struct {
    longint unsigned res;
    longint unsigned a;
    longint unsigned b;
    bit              mode;
    logic [TW-1:0]   tag;
    int              acc_cyc;
    int              acc_stall;
    bit              has_lit;
    longint unsigned lit;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int stall_cnt = 0;
  bit prev_stall = 0;
  logic [15:0]   prev_res;
  logic [TW-1:0] prev_tag;
  logic          prev_mode;
  bit      cur_has_lit = 0, c16_has_lit = 0;
  longint  cur_lit = 0, c16_lit = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: product from the exact/Mitchell definitions in plain arithmetic.
  function automatic longint unsigned ref_mult(input int w, input longint unsigned a,
                                               input longint unsigned b, input bit m);
    int f, ka, kb, kk;
    longint unsigned xa, xb, x, one;
    one = 64'd1;
    if (m == MODE_EXACT) return a * b;
    if (a == 0 || b == 0) return 0;
    f  = w - 1;
    ka = $clog2(a + 1) - 1;
    kb = $clog2(b + 1) - 1;
    xa = (a - (one << ka)) << (f - ka);
    xb = (b - (one << kb)) << (f - kb);
    kk = ka + kb;
    x  = xa + xb;
    if (x < (one << f)) return (((one << f) + x) << kk) >> f;
    return (x << (kk + 1)) >> f;
  endfunction

  // 8-bit scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", out_result, prev_res);
        chk("hold_tag", out_tag, prev_tag);
        chk("hold_mode", out_mode, prev_mode);
      end
      if (in_valid && in_ready) begin
        e8.res = ref_mult(8, in_a, in_b, in_mode);
        e8.a = in_a; e8.b = in_b; e8.mode = in_mode; e8.tag = in_tag;
        e8.acc_cyc = cyc; e8.acc_stall = stall_cnt;
        e8.has_lit = cur_has_lit; e8.lit = cur_lit;
        q8.push_back(e8);
      end
      if (out_valid && out_ready) begin
        if (q8.size() == 0) begin
          chk("unexpected_output8", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e8 = q8.pop_front();
          chk("result8", out_result, e8.res);
          chk("mode8", out_mode, e8.mode);
          chk("tag8", out_tag, e8.tag);
          chk("latency8", cyc - e8.acc_cyc, 3 + stall_cnt - e8.acc_stall);
          if (e8.has_lit) chk("directed8", out_result, e8.lit);
          if (e8.mode) chk("mitchell_le_exact8", out_result <= e8.a * e8.b, 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_res = out_result; prev_tag = out_tag; prev_mode = out_mode;
      if (prev_stall) stall_cnt++;
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (d16_in_valid && d16_in_ready) begin
        e16.res = ref_mult(16, d16_in_a, d16_in_b, d16_in_mode);
        e16.a = d16_in_a; e16.b = d16_in_b; e16.mode = d16_in_mode; e16.tag = d16_in_tag;
        e16.acc_cyc = 0; e16.acc_stall = 0;
        e16.has_lit = c16_has_lit; e16.lit = c16_lit;
        q16.push_back(e16);
      end
      if (d16_out_valid && d16_out_ready) begin
        if (q16.size() == 0) begin
          chk("unexpected_output16", d16_out_result, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e16 = q16.pop_front();
          chk("result16", d16_out_result, e16.res);
          chk("mode16", d16_out_mode, e16.mode);
          chk("tag16", d16_out_tag, e16.tag);
          if (e16.has_lit) chk("directed16", d16_out_result, e16.lit);
          if (e16.mode) chk("mitchell_le_exact16", d16_out_result <= e16.a * e16.b, 1);
        end
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic m,
                       input logic [TW-1:0] t, input longint lit);
    int n = 0;
    in_a = a; in_b = b; in_mode = m; in_tag = t;
    cur_has_lit = (lit >= 0); cur_lit = lit; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      if (n > 100) begin chk("send8_timeout", 0, 1); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; cur_has_lit = 0;
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic m,
                        input logic [TW-1:0] t, input longint lit);
    int n = 0;
    d16_in_a = a; d16_in_b = b; d16_in_mode = m; d16_in_tag = t;
    c16_has_lit = (lit >= 0); c16_lit = lit; d16_in_valid = 1'b1;
    @(negedge clk);
    while (!d16_in_ready) begin
      n++;
      if (n > 100) begin chk("send16_timeout", 0, 1); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    d16_in_valid = 1'b0; c16_has_lit = 0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, q8.size() + q16.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_a = 0; in_b = 0; in_mode = 0; in_tag = 0; out_ready = 1;
    d16_in_valid = 0; d16_in_a = 0; d16_in_b = 0; d16_in_mode = 0; d16_in_tag = 0; d16_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_out_tag", out_tag, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid16", d16_out_valid, 0);
    @(posedge clk); #1;

    // Exact directed
    send8(5, 7, MODE_EXACT, 1, 35);
    send8(15, 16, MODE_EXACT, 2, 240);
    send8(255, 255, MODE_EXACT, 3, 65025);
    send8(123, 45, MODE_EXACT, 4, 5535);
    drain("drain_exact");

    // Mitchell directed
    send8(3, 3, MODE_MITCHELL, 5, 8);
    send8(5, 7, MODE_MITCHELL, 6, 32);
    send8(15, 16, MODE_MITCHELL, 7, 240);
    send8(255, 255, MODE_MITCHELL, 8, 65024);
    send8(0, 200, MODE_MITCHELL, 9, 0);
    send8(1, 1, MODE_MITCHELL, 10, 1);
    drain("drain_mitchell");

    // Mixed-mode back to back
    send8(5, 7, MODE_EXACT, 11, 35);
    send8(5, 7, MODE_MITCHELL, 12, 32);
    send8(5, 7, MODE_EXACT, 13, 35);
    drain("drain_mixed");

    // Backpressure window during a 6-transaction stream
    fork
      begin
        for (int i = 0; i < 6; i++)
          send8(8'(20 + i), 8'(3 + i), logic'(i % 2), TW'(i), -1);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_backpressure");

    // Reset with three transactions in flight
    send8(9, 10, MODE_EXACT, 1, -1);
    send8(11, 12, MODE_MITCHELL, 2, -1);
    send8(13, 14, MODE_EXACT, 3, -1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_result", out_result, 0);
    q8.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send8(9, 9, MODE_EXACT, 14, 81);
    drain("drain_post_reset");

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      in_b      = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 255));
      in_mode   = logic'($urandom_range(0, 1));
      in_tag    = TW'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain("drain_random8");

    // 16-bit instance
    send16(16'hFFFF, 16'hFFFF, MODE_EXACT, 1, 64'd4294836225);
    send16(16'hFFFF, 16'hFFFF, MODE_MITCHELL, 2, 64'd4294836224);
    for (int i = 0; i < 60; i++)
      send16(16'($urandom_range(0, 65535)), 16'($urandom_range(1, 65535)),
             logic'($urandom_range(0, 1)), TW'(i), -1);
    drain("drain_random16");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/log_mult_pipe.md
Name: log_mult_pipe

Overview:
- Parametrised, 3-stage pipelined unsigned multiplier; successor to the fixed 8-bit combinational Wallace multiplier.
- Each transaction selects its own mode: exact product or Mitchell logarithmic approximate product.
- Valid/ready on both sides with full backpressure; sits between operand sources and error-analysis/accumulator logic in the approximate-multiplier datapath.

Parameters:
- WIDTH, 8, operand width in bits (legal range 4..32); result is 2*WIDTH bits.
- TAG_W, 4, width of the opaque transaction tag carried alongside each operand pair.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts operands this cycle
- in_a  input  WIDTH  multiplicand, unsigned
- in_b  input  WIDTH  multiplier, unsigned
- in_mode  input  1  0 = exact, 1 = Mitchell approximate
- in_tag  input  TAG_W  user tag, returned unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_result  output  2*WIDTH  product
- out_mode  output  1  mode used for this result
- out_tag  output  TAG_W  tag of this result

Behaviour:
- Reset (async assert, sync release): all stage valid bits cleared; out_valid=0, out_result=0, out_mode=0, out_tag=0. in_ready=1 once reset is deasserted. Reset mid-operation discards all in-flight transactions.
- Pipeline: S1 (register operands, leading-one positions, fractions), S2 (exact partial product / log sum), S3 (antilog shift, output register).
- Latency: exactly 3 cycles from accept to out_valid when not stalled.
- Throughput: 1 transaction per cycle.
- Stall: advance = !(out_valid && !out_ready).
  - in_ready = advance, combinational; in_ready does not depend on in_valid.
  - When advance=0, all stages hold their contents.
  - Bubbles are not compressed.
- Transfer occurs only on valid && ready. Output data holds stable while out_valid=1 and out_ready=0.
- Exact mode: out_result = in_a * in_b, full 2*WIDTH bits, no truncation.
- Approximate mode (F = WIDTH-1 fraction bits):
  - If either operand is 0, result = 0.
  - Otherwise, with k = index of the most significant 1: ka = msb(a), kb = msb(b); xa = (a << (F-ka)) mod 2^F; likewise xb.
  - K = ka + kb; X = xa + xb (F+1 bits).
  - If X < 2^F: result = ((2^F + X) << K) >> F.
  - Else: result = (X << (K+1)) >> F.
  - Truncate, no rounding. Result is always <= the exact product.
- Mode and tag travel with their data. Mixed-mode back-to-back transactions are legal and each is computed in its own mode.
- Simultaneous out-accept and in-accept in the same cycle is legal: the pipeline shifts and new data enters S1.

Decomposition:
- Package log_mult_pkg holds:
  - mode encoding constants MODE_EXACT=0, MODE_MITCHELL=1
  - function clog2-based width helper for the leading-one index width
- Sub-module lod (leading-one detector): parameter WIDTH; outputs the index of the MSB set and a zero flag. Instantiated twice in S1.

Test Plan:
- Exact, WIDTH=8, out_ready=1: pairs (5,7), (15,16), (255,255), (123,45) with tags 1..4 -> results 35, 240, 65025, 5535. Each appears 3 cycles after accept, in order, with matching tags.
- Mitchell, WIDTH=8: (3,3) -> 8; (5,7) -> 32; (15,16) -> 240; (255,255) -> 65024; (0,200) -> 0; (1,1) -> 1.
- Mixed mode back-to-back: (5,7) exact, (5,7) Mitchell, (5,7) exact on consecutive cycles -> 35, 32, 35 with out_mode 0, 1, 0.
- Backpressure: stream 6 transactions with out_ready held 0 for cycles 4..8.
  - in_ready drops in the same cycle the stall begins.
  - out_result stays stable while stalled.
  - No loss or duplication; all 6 results arrive in order.
- Reset mid-stream: assert rst_n=0 with 3 transactions in flight -> out_valid=0 immediately (asynchronous). No stale result appears after release; the first post-reset transaction has latency 3.
- WIDTH=16 instance: exact 65535*65535 -> 4294836225. Mitchell 65535*65535 -> computed per the formula (4294836224) and <= exact.
